// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch resolution
// and the EX->MEM pipeline register.
module ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RFW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id2ex_pc,
  input  logic            id2ex_reg_wen,
  input  logic [RFW-1:0]  id2ex_reg_waddr,
  input  logic [XLEN-1:0] id2ex_op1_data,
  input  logic [XLEN-1:0] id2ex_op2_data,
  input  logic [XLEN-1:0] id2ex_imm_value,
  input  logic [3:0]      id2ex_alu_op,
  input  logic [2:0]      id2ex_mem_rd_op,
  input  logic [1:0]      id2ex_mem_wr_op,
  input  logic            id2ex_br_instr,
  input  logic [2:0]      id2ex_branch_op,
  input  logic            id2ex_sel_imm,
  input  logic            id2ex_op1_forward_from_mem,
  input  logic            id2ex_op1_forward_from_wb,
  input  logic            id2ex_op2_forward_from_mem,
  input  logic            id2ex_op2_forward_from_wb,
  input  logic            id2ex_ill_instr,
  input  logic [XLEN-1:0] wb_reg_wdata,
  input  logic            lsu_mem_rd,
  output logic [XLEN-1:0] lsu_addr,
  output logic [XLEN-1:0] lsu_wdata,
  output logic [XLEN-1:0] target_pc,
  output logic            take_branch,
  output logic            ex2mem_reg_wen,
  output logic [RFW-1:0]  ex2mem_reg_waddr,
  output logic [XLEN-1:0] ex2mem_alu_out,
  output logic            ex2mem_mem_rd,
  output logic            ex2mem_ill_instr
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
    ALU_XOR   = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
    ALU_SLT   = 4'd8,  ALU_SLTU = 4'd9,  ALU_PASSB = 4'd10, ALU_AUIPC = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ = 3'd0, BR_BNE = 3'd1, BR_BLT = 3'd2, BR_BGE  = 3'd3,
    BR_BLTU = 3'd4, BR_BGEU = 3'd5, BR_JAL = 3'd6, BR_JALR = 3'd7
  } br_op_e;

  alu_op_e         alu_op;
  br_op_e          br_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_fwd;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] a_imm;
  logic            br_cond;
  logic            is_jump;
  logic            unused_ops;

  // Decoded memory ops are consumed by the LSU directly; EX only passes data.
  assign unused_ops = ^{id2ex_mem_rd_op, id2ex_mem_wr_op};

  assign alu_op = alu_op_e'(id2ex_alu_op);
  assign br_op  = br_op_e'(id2ex_branch_op);

  assign op_a     = id2ex_op1_forward_from_mem ? ex2mem_alu_out :
                    id2ex_op1_forward_from_wb  ? wb_reg_wdata   : id2ex_op1_data;
  assign op_b_fwd = id2ex_op2_forward_from_mem ? ex2mem_alu_out :
                    id2ex_op2_forward_from_wb  ? wb_reg_wdata   : id2ex_op2_data;
  assign op_b     = id2ex_sel_imm ? id2ex_imm_value : op_b_fwd;

  assign pc_imm = id2ex_pc + id2ex_imm_value;
  assign a_imm  = op_a + id2ex_imm_value;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB: alu_res = op_b;
      ALU_AUIPC: alu_res = pc_imm;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (br_op)
      BR_BEQ:  br_cond = (op_a == op_b_fwd);
      BR_BNE:  br_cond = (op_a != op_b_fwd);
      BR_BLT:  br_cond = ($signed(op_a) <  $signed(op_b_fwd));
      BR_BGE:  br_cond = ($signed(op_a) >= $signed(op_b_fwd));
      BR_BLTU: br_cond = (op_a <  op_b_fwd);
      BR_BGEU: br_cond = (op_a >= op_b_fwd);
      BR_JAL:  br_cond = 1'b1;
      BR_JALR: br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign is_jump     = id2ex_br_instr & ((br_op == BR_JAL) | (br_op == BR_JALR));
  assign result      = is_jump ? (id2ex_pc + XLEN'(4)) : alu_res;
  assign take_branch = id2ex_br_instr & br_cond;
  assign target_pc   = (br_op == BR_JALR) ? {a_imm[XLEN-1:1], 1'b0} : pc_imm;
  assign lsu_addr    = a_imm;
  assign lsu_wdata   = op_b_fwd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex2mem_reg_wen   <= 1'b0;
      ex2mem_reg_waddr <= '0;
      ex2mem_alu_out   <= '0;
      ex2mem_mem_rd    <= 1'b0;
      ex2mem_ill_instr <= 1'b0;
    end else begin
      ex2mem_reg_wen   <= id2ex_reg_wen & ~id2ex_ill_instr & (id2ex_reg_waddr != '0);
      ex2mem_reg_waddr <= id2ex_reg_waddr;
      ex2mem_alu_out   <= result;
      ex2mem_mem_rd    <= lsu_mem_rd;
      ex2mem_ill_instr <= id2ex_ill_instr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, op1, op2, imm, wb;
  logic        reg_wen, br_instr, sel_imm, ill, mem_rd;
  logic [4:0]  waddr;
  logic [3:0]  alu_op;
  logic [2:0]  mem_rd_op, br_op;
  logic [1:0]  mem_wr_op;
  logic        fm1, fw1, fm2, fw2;
  logic [31:0] lsu_addr, lsu_wdata, target_pc, ex_alu_out;
  logic        take_branch, ex_wen, ex_mem_rd, ex_ill;
  logic [4:0]  ex_waddr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] m_alu_out;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .RFW(5)) dut (
    .clk(clk), .rst(rst),
    .id2ex_pc(pc), .id2ex_reg_wen(reg_wen), .id2ex_reg_waddr(waddr),
    .id2ex_op1_data(op1), .id2ex_op2_data(op2), .id2ex_imm_value(imm),
    .id2ex_alu_op(alu_op), .id2ex_mem_rd_op(mem_rd_op), .id2ex_mem_wr_op(mem_wr_op),
    .id2ex_br_instr(br_instr), .id2ex_branch_op(br_op), .id2ex_sel_imm(sel_imm),
    .id2ex_op1_forward_from_mem(fm1), .id2ex_op1_forward_from_wb(fw1),
    .id2ex_op2_forward_from_mem(fm2), .id2ex_op2_forward_from_wb(fw2),
    .id2ex_ill_instr(ill), .wb_reg_wdata(wb), .lsu_mem_rd(mem_rd),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .target_pc(target_pc),
    .take_branch(take_branch), .ex2mem_reg_wen(ex_wen), .ex2mem_reg_waddr(ex_waddr),
    .ex2mem_alu_out(ex_alu_out), .ex2mem_mem_rd(ex_mem_rd), .ex2mem_ill_instr(ex_ill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: instruction semantics written directly from the ISA rules.
  task automatic model(output logic [31:0] addr, output logic [31:0] wdata,
                       output logic [31:0] tpc, output logic [31:0] res,
                       output logic take);
    logic [31:0] a, bf, b;
    logic        cond;
    a  = fm1 ? m_alu_out : (fw1 ? wb : op1);
    bf = fm2 ? m_alu_out : (fw2 ? wb : op2);
    b  = sel_imm ? imm : bf;
    case (alu_op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = a << b[4:0];
      4'd6:  res = a >> b[4:0];
      4'd7:  res = $signed(a) >>> b[4:0];
      4'd8:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  res = (a < b) ? 32'd1 : 32'd0;
      4'd10: res = b;
      4'd11: res = pc + imm;
      default: res = 32'd0;
    endcase
    case (br_op)
      3'd0: cond = (a == bf);
      3'd1: cond = (a != bf);
      3'd2: cond = ($signed(a) < $signed(bf));
      3'd3: cond = ($signed(a) >= $signed(bf));
      3'd4: cond = (a < bf);
      3'd5: cond = (a >= bf);
      default: cond = 1'b1;
    endcase
    if (br_instr && br_op >= 3'd6) res = pc + 32'd4;
    take  = br_instr & cond;
    tpc   = (br_op == 3'd7) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    addr  = a + imm;
    wdata = bf;
  endtask

  task automatic clear_inputs();
    pc = 32'h0; op1 = 32'h0; op2 = 32'h0; imm = 32'h0; wb = 32'h0;
    reg_wen = 1'b0; waddr = 5'd0; alu_op = 4'd0; mem_rd_op = 3'd0; mem_wr_op = 2'd0;
    br_instr = 1'b0; br_op = 3'd0; sel_imm = 1'b0; ill = 1'b0; mem_rd = 1'b0;
    fm1 = 1'b0; fw1 = 1'b0; fm2 = 1'b0; fw2 = 1'b0;
  endtask

  // Inputs are already applied; check combinational outputs, clock, check registers.
  task automatic step();
    logic [31:0] e_addr, e_wdata, e_tpc, e_res;
    logic        e_take;
    model(e_addr, e_wdata, e_tpc, e_res, e_take);
    #1;
    check("lsu_addr", lsu_addr, e_addr);
    check("lsu_wdata", lsu_wdata, e_wdata);
    check("target_pc", target_pc, e_tpc);
    check("take_branch", {31'd0, take_branch}, {31'd0, e_take});
    @(posedge clk);
    #1;
    check("alu_out", ex_alu_out, e_res);
    check("reg_wen", {31'd0, ex_wen}, {31'd0, reg_wen & ~ill & (waddr != 5'd0)});
    check("reg_waddr", {27'd0, ex_waddr}, {27'd0, waddr});
    check("mem_rd", {31'd0, ex_mem_rd}, {31'd0, mem_rd});
    check("ill_instr", {31'd0, ex_ill}, {31'd0, ill});
    m_alu_out = e_res;
    last_res  = e_res;
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clear_inputs();
    m_alu_out = 32'h0;
    last_res  = 32'h0;
    rst = 1'b0;
    #1;
    check("rst_alu_out", ex_alu_out, 32'h0);
    check("rst_reg_wen", {31'd0, ex_wen}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD overflow wraps
    clear_inputs(); alu_op = 4'd0; op1 = 32'h7FFF_FFFF; op2 = 32'h1; reg_wen = 1'b1; waddr = 5'd3;
    step(); check("add_wrap", ex_alu_out, 32'h8000_0000);
    // SUB 0-1
    clear_inputs(); alu_op = 4'd1; op1 = 32'h0; op2 = 32'h1;
    step(); check("sub_wrap", ex_alu_out, 32'hFFFF_FFFF);
    // SRA via immediate
    clear_inputs(); alu_op = 4'd7; op1 = 32'h8000_0000; imm = 32'd4; sel_imm = 1'b1;
    step(); check("sra", ex_alu_out, 32'hF800_0000);
    clear_inputs(); alu_op = 4'd8; op1 = 32'hFFFF_FFFF; op2 = 32'd1;
    step(); check("slt", ex_alu_out, 32'd1);
    clear_inputs(); alu_op = 4'd9; op1 = 32'hFFFF_FFFF; op2 = 32'd1;
    step(); check("sltu", ex_alu_out, 32'd0);
    // MEM forward wins over WB
    clear_inputs(); alu_op = 4'd0; op1 = 32'd2; op2 = 32'd3;
    step();
    clear_inputs(); alu_op = 4'd0; fm1 = 1'b1; fw1 = 1'b1; wb = 32'd9; op1 = 32'd77;
    #1; check("fwd_prio_addr", lsu_addr, 32'd5);
    step(); check("fwd_prio_res", ex_alu_out, 32'd5);
    // BNE backward
    clear_inputs(); br_instr = 1'b1; br_op = 3'd1; pc = 32'h100; imm = 32'hFFFF_FFF8;
    op1 = 32'd1; op2 = 32'd2;
    #1; check("bne_take", {31'd0, take_branch}, 32'd1); check("bne_tgt", target_pc, 32'hF8);
    step();
    // JALR clears bit 0, writes pc+4
    clear_inputs(); br_instr = 1'b1; br_op = 3'd7; pc = 32'h40; imm = 32'd2; op1 = 32'h203;
    alu_op = 4'd1; reg_wen = 1'b1; waddr = 5'd1;
    #1; check("jalr_tgt", target_pc, 32'h204);
    step(); check("jalr_link", ex_alu_out, 32'h44);
    clear_inputs(); br_instr = 1'b1; br_op = 3'd5; op1 = 32'd1; op2 = 32'hFFFF_FFFF;
    #1; check("bgeu_nt", {31'd0, take_branch}, 32'd0);
    step();
    // x0 and illegal suppress write-back
    clear_inputs(); reg_wen = 1'b1; waddr = 5'd0; op1 = 32'd7;
    step(); check("x0_wen", {31'd0, ex_wen}, 32'd0);
    clear_inputs(); reg_wen = 1'b1; waddr = 5'd9; ill = 1'b1;
    step(); check("ill_wen", {31'd0, ex_wen}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      pc = {$urandom_range(0, 32'h3FFF), 2'b00};
      op1 = rnd_data(); op2 = ($urandom_range(0, 3) == 0) ? op1 : rnd_data();
      imm = rnd_data(); wb = rnd_data();
      reg_wen = 1'($urandom); waddr = 5'($urandom); ill = ($urandom_range(0, 7) == 0);
      alu_op = 4'($urandom); br_op = 3'($urandom); br_instr = ($urandom_range(0, 3) == 0);
      sel_imm = 1'($urandom); mem_rd = 1'($urandom);
      mem_rd_op = 3'($urandom); mem_wr_op = 2'($urandom);
      fm1 = 1'($urandom); fw1 = 1'($urandom); fm2 = 1'($urandom); fw2 = 1'($urandom);
      step();
      // Asynchronous reset mid-run, asserted away from any clock edge
      if (i == 200) begin
        clear_inputs();
        op1 = 32'h1234; reg_wen = 1'b1; waddr = 5'd5; mem_rd = 1'b1; ill = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        check("arst_alu_out", ex_alu_out, 32'h0);
        check("arst_wen", {31'd0, ex_wen}, 32'h0);
        check("arst_waddr", {27'd0, ex_waddr}, 32'h0);
        check("arst_mem_rd", {31'd0, ex_mem_rd}, 32'h0);
        check("arst_ill", {31'd0, ex_ill}, 32'h0);
        m_alu_out = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_hold", ex_alu_out, 32'h1234);
        m_alu_out = 32'h1234;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
